// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button debouncer: default counter width and
// the FSM state codes that also drive the debug LEDs.
package button_debouncer_pkg;

  // Default debounce counter width: 2^20-1 cycles is about 10.5 ms at 100 MHz.
  localparam int N_DC_DEFAULT = 20;

  // State codes, shared with the LED decoders elsewhere in the design.
  localparam logic [2:0] ST_INI      = 3'd0;
  localparam logic [2:0] ST_WQ       = 3'd1;
  localparam logic [2:0] ST_SCEN     = 3'd2;
  localparam logic [2:0] ST_MCEN_CNT = 3'd3;
  localparam logic [2:0] ST_MCEN     = 3'd4;
  localparam logic [2:0] ST_CCR      = 3'd5;

  // The debounced level is high in every state from the confirmed press
  // until the release has been confirmed.
  function automatic logic is_pressed_state(input logic [2:0] st);
    return (st == ST_SCEN) || (st == ST_MCEN_CNT) ||
           (st == ST_MCEN) || (st == ST_CCR);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the Clk
// domain. Only q may be used by downstream logic.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw button, qualifies press and
// release with a 2^N_DC-1 cycle counter, and produces a debounced level, a
// single-cycle press enable and an auto-repeat enable. All outputs are decoded
// from the registered state, so there is no combinational path from PB.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_DC = N_DC_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PB,
  output logic       DPB,
  output logic       SCEN,
  output logic       MCEN,
  output logic [2:0] State
);

  localparam logic [N_DC-1:0] CNT_MAX = '1;

  logic            pb_s;
  logic [2:0]      state_reg;
  logic [N_DC-1:0] cnt_reg;
  logic            cnt_max;

  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (PB),
    .q     (pb_s)
  );

  assign cnt_max = (cnt_reg == CNT_MAX);

  // FSM and debounce counter; every state change restarts the count from zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_INI;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INI: begin
          if (pb_s) begin
            state_reg <= ST_WQ;
            cnt_reg   <= '0;
          end
        end
        ST_WQ: begin
          if (!pb_s) begin
            state_reg <= ST_INI;           // bounce rejected
            cnt_reg   <= '0;
          end else if (cnt_max) begin
            state_reg <= ST_SCEN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + N_DC'(1);
          end
        end
        ST_SCEN: begin
          state_reg <= ST_MCEN_CNT;
          cnt_reg   <= '0;
        end
        ST_MCEN_CNT: begin
          if (!pb_s) begin
            state_reg <= ST_CCR;
            cnt_reg   <= '0;
          end else if (cnt_max) begin
            state_reg <= ST_MCEN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + N_DC'(1);
          end
        end
        ST_MCEN: begin
          state_reg <= ST_MCEN_CNT;
          cnt_reg   <= '0;
        end
        ST_CCR: begin
          if (pb_s) begin
            cnt_reg <= '0;                 // still bouncing: restart release timing
          end else if (cnt_max) begin
            state_reg <= ST_INI;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + N_DC'(1);
          end
        end
        default: begin
          state_reg <= ST_INI;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Moore output decode from the state register only.
  assign DPB   = is_pressed_state(state_reg);
  assign SCEN  = (state_reg == ST_SCEN);
  assign MCEN  = (state_reg == ST_SCEN) || (state_reg == ST_MCEN);
  assign State = state_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with N_DC=4. A timing model built
// from run lengths of the synchronized button level predicts DPB/SCEN/MCEN
// every cycle; scenario tasks also check the absolute edge numbers directly.
module tb_button_debouncer;
  import button_debouncer_pkg::*;

  localparam int N_DC    = 4;
  localparam int PERIOD  = 2 ** N_DC;   // 16
  localparam int PRESS_N = PERIOD + 1;  // consecutive high samples to accept a press
  localparam int REP_N   = PERIOD + 1;  // edges between enable pulses while held
  localparam int REL_N   = PERIOD;      // consecutive low samples to confirm release

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       PB = 1'b1;
  logic       DPB, SCEN, MCEN;
  logic [2:0] State;

  int vectors = 0;
  int miscompares = 0;

  button_debouncer #(.N_DC(N_DC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .PB    (PB),
    .DPB   (DPB),
    .SCEN  (SCEN),
    .MCEN  (MCEN),
    .State (State)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  bit m_s1, m_s2;      // PB delayed through the two synchronizer stages
  bit m_pressed;       // expected debounced level
  bit m_releasing;     // a low was seen while pressed, release not yet confirmed
  int m_run;           // length of the qualifying run of samples
  int m_since;         // edges since the last enable pulse while held
  bit m_scen, m_mcen;  // expected enables for the cycle after this edge

  function automatic void model_edge(input bit pb, input bit rst);
    bit seen;
    seen   = m_s2;
    m_scen = 1'b0;
    m_mcen = 1'b0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_releasing = 0; m_run = 0; m_since = 0;
      return;
    end
    m_s2 = m_s1;
    m_s1 = pb;
    if (!m_pressed) begin
      m_run = seen ? m_run + 1 : 0;
      if (m_run == PRESS_N) begin
        m_pressed = 1; m_releasing = 0; m_scen = 1; m_mcen = 1; m_since = 0; m_run = 0;
      end
    end else if (!m_releasing) begin
      // the edge right after a pulse does not look at the button
      m_since++;
      if (m_since >= 2 && !seen) begin
        m_releasing = 1; m_run = 0;
      end else if (m_since == REP_N) begin
        m_mcen = 1; m_since = 0;
      end
    end else begin
      m_run = seen ? 0 : m_run + 1;
      if (m_run == REL_N) begin
        m_pressed = 0; m_releasing = 0; m_run = 0;
      end
    end
  endfunction

  // Drive one cycle: inputs change on the falling edge, model follows the rising edge.
  task automatic tick(input logic pb, input logic rst);
    @(negedge Clk);
    PB    = pb;
    Reset = rst;
    @(posedge Clk);
    model_edge(pb, rst);
    #1;
  endtask

  task automatic test_reset();
    int scen_n = 0, scen_at = -1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if ({State, DPB, SCEN, MCEN} !== {ST_INI, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d: State=%0d DPB/SCEN/MCEN=%b%b%b required State=0 outputs 000",
                 i, State, DPB, SCEN, MCEN);
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL reset_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (SCEN === 1'b1) begin scen_n++; scen_at = i; end
    end
    vectors++;
    if (scen_n != 1 || scen_at != 18) begin
      miscompares++;
      $display("FAIL reset_single_scen: count=%0d last edge=%0d required count=1 edge=18", scen_n, scen_at);
    end
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    int scen_n = 0, scen_at = -1, dpb_rise = -1, dpb_fall = -1, extra = 0;
    int mcen_at[$];
    int exp_m[3] = '{18, 35, 52};
    bit ok;
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL clean_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (SCEN === 1'b1) begin scen_n++; scen_at = i; end
      if (MCEN === 1'b1) mcen_at.push_back(i);
      if (DPB === 1'b1 && dpb_rise < 0) dpb_rise = i;
    end
    vectors++;
    if (scen_n != 1 || scen_at != 18) begin
      miscompares++;
      $display("FAIL clean_scen: count=%0d edge=%0d required count=1 edge=18", scen_n, scen_at);
    end
    ok = (mcen_at.size() == 3);
    if (ok) for (int k = 0; k < 3; k++) if (mcen_at[k] != exp_m[k]) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL clean_mcen: %0d pulses, first at %0d, required pulses at 18,35,52",
               mcen_at.size(), (mcen_at.size() > 0) ? mcen_at[0] : -1);
    end
    vectors++;
    if (dpb_rise != 18) begin
      miscompares++;
      $display("FAIL clean_dpb_rise: edge=%0d required 18", dpb_rise);
    end
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL clean_rel_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (DPB === 1'b0 && dpb_fall < 0) dpb_fall = i;
      if (SCEN === 1'b1 || MCEN === 1'b1) extra++;
    end
    vectors++;
    if (dpb_fall != 18 || extra != 0) begin
      miscompares++;
      $display("FAIL clean_release: DPB fell at %0d with %0d enables, required 18 with 0", dpb_fall, extra);
    end
  endtask

  task automatic test_bounce_press();
    int scen_n = 0, scen_at = -1;
    logic pb;
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 95; i++) begin
      if (i < 30)      pb = ((i / 3) % 2 == 0);
      else if (i < 70) pb = 1'b1;
      else             pb = 1'b0;
      tick(pb, 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL bounce_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (SCEN === 1'b1) begin scen_n++; scen_at = i; end
    end
    // final rising edge is sampled at edge 30, so SCEN follows edge 48
    vectors++;
    if (scen_n != 1 || scen_at != 48) begin
      miscompares++;
      $display("FAIL bounce_scen: count=%0d edge=%0d required count=1 edge=48", scen_n, scen_at);
    end
  endtask

  task automatic test_release_bounce();
    int dpb_fall = -1, extra = 0, early_low = 0;
    logic pb;
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      pb = (i >= 5 && i < 7);
      tick(pb, 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL relb_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (DPB === 1'b0 && dpb_fall < 0) dpb_fall = i;
      if (DPB !== 1'b1 && i < 7) early_low++;
      if (SCEN === 1'b1 || MCEN === 1'b1) extra++;
    end
    // The high during confirm-release clears the count without leaving CCR, so
    // no low sample is spent on a state change: the final low run seen from
    // edge 7 needs 16 synchronized lows, landing on edge 7+2+15 = 24.
    vectors++;
    if (dpb_fall != 24 || early_low != 0 || extra != 0) begin
      miscompares++;
      $display("FAIL relb_release: fall=%0d early_low=%0d enables=%0d required fall=24 early_low=0 enables=0",
               dpb_fall, early_low, extra);
    end
  endtask

  task automatic test_short_glitch();
    int active = 0;
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 35; i++) begin
      tick((i < 10), 1'b0);
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL glitch_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (DPB !== 1'b0 || SCEN !== 1'b0 || MCEN !== 1'b0) active++;
    end
    vectors++;
    if (active != 0 || State !== ST_INI) begin
      miscompares++;
      $display("FAIL glitch_quiet: active cycles=%0d State=%0d required 0 and State=0", active, State);
    end
  endtask

  task automatic test_reset_mid_hold();
    int scen_at[$];
    tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, (i == 25));
      vectors++;
      if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen}) begin
        miscompares++;
        $display("FAIL midrst_model edge %0d: DPB/SCEN/MCEN=%b%b%b required %b%b%b",
                 i, DPB, SCEN, MCEN, m_pressed, m_scen, m_mcen);
      end
      if (i == 25) begin
        vectors++;
        if ({State, DPB, SCEN, MCEN} !== {ST_INI, 3'b000}) begin
          miscompares++;
          $display("FAIL midrst_clear: State=%0d DPB/SCEN/MCEN=%b%b%b required 0/000", State, DPB, SCEN, MCEN);
        end
      end
      if (SCEN === 1'b1) scen_at.push_back(i);
    end
    // fresh SCEN 19 edges after the reset edge: edges 26..44
    vectors++;
    if (scen_at.size() != 2 || scen_at[0] != 18 || scen_at[1] != 44) begin
      miscompares++;
      $display("FAIL midrst_scen: %0d pulses, last at %0d, required pulses at 18 and 44",
               scen_at.size(), (scen_at.size() > 0) ? scen_at[scen_at.size() - 1] : -1);
    end
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int len;
    for (int seg = 0; seg < 60; seg++) begin
      lvl = ~lvl;
      len = (seg % 4 == 0) ? $urandom_range(1, 6) : $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        tick(lvl, ($urandom_range(0, 199) == 0));
        vectors++;
        if ({DPB, SCEN, MCEN} !== {m_pressed, m_scen, m_mcen} ||
            ((State === ST_INI) != (!m_pressed && m_run == 0))) begin
          miscompares++;
          $display("FAIL random_model seg %0d cyc %0d: DPB/SCEN/MCEN=%b%b%b State=%0d required %b%b%b idle=%0b",
                   seg, i, DPB, SCEN, MCEN, State, m_pressed, m_scen, m_mcen, (!m_pressed && m_run == 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_release_bounce();
    test_short_glitch();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
